conv_layer_stream: RTL

- Parametrised successor to the fixed 4-kernel first conv layer.
- Streams ifmap columns (ROWS x DATA_W) through a 3-column sliding window and computes NUM_KERNEL 3x3 convolutions per output column.
- Holds all filter weights in an internal register bank, loaded through a handshaked port.
- Valid/ready on input and output, frame delimiting, saturation to PSUM_W. Sits between the ifmap column buffer and the layer-2 psum buffer.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv_kernel_col.sv | 51 +++++
 rtl/conv_layer_stream.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared defaults, FSM state encoding and the saturating clip for the
// streaming 3x3 convolution layer.
package conv_pkg;

  localparam int NUM_KERNEL_DEF = 4;
  localparam int ROWS_DEF       = 26;
  localparam int DATA_W_DEF     = 8;
  localparam int WGT_W_DEF      = 4;
  localparam int PSUM_W_DEF     = 14;

  typedef enum logic [1:0] {
    ST_WLOAD  = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  function automatic int beat_cnt_w(input int num_kernel);
    return (num_kernel * 3 > 1) ? $clog2(num_kernel * 3) : 1;
  endfunction

  // Clip to a signed psum_w range; relu additionally floors at zero.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int psum_w,
                                                  input logic relu);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    hi = (32'sd1 <<< (psum_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (psum_w - 1));
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/conv_kernel_col.sv
// One 3x3 filter applied down a full 3-column window, producing ROWS-2
// saturated sums (combinational). CONV_LAYER_STREAM_RELU_EN floors results at 0.
module conv_kernel_col
  import conv_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WGT_W  = WGT_W_DEF,
  parameter int PSUM_W = PSUM_W_DEF
) (
  input  logic [9*WGT_W-1:0]           wgt,
  input  logic [3*ROWS*DATA_W-1:0]     win,
  output logic [(ROWS-2)*PSUM_W-1:0]   psum
);

  localparam int OUT_ROWS = ROWS - 2;
  localparam int SUM_W    = DATA_W + WGT_W + 5;
  localparam int COL_W    = ROWS * DATA_W;
`ifdef CONV_LAYER_STREAM_RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif

  // Window column 0 (MSBs) is the oldest and meets weight column 0.
  always_comb begin
    logic signed [SUM_W-1:0] acc;
    logic signed [SUM_W-1:0] px;
    logic signed [SUM_W-1:0] wv;
    logic [WGT_W-1:0]        w_tap;
    acc   = '0;
    px    = '0;
    wv    = '0;
    w_tap = '0;
    psum  = '0;
    for (int o = 0; o < OUT_ROWS; o++) begin
      acc = '0;
      for (int j = 0; j < 3; j++) begin
        for (int r = 0; r < 3; r++) begin
          px    = {{(SUM_W-DATA_W){1'b0}}, win[(2-j)*COL_W + (ROWS-1-o-r)*DATA_W +: DATA_W]};
          w_tap = wgt[(2-j)*3*WGT_W + (2-r)*WGT_W +: WGT_W];
          wv    = {{(SUM_W-WGT_W){w_tap[WGT_W-1]}}, w_tap};
          acc   = acc + px * wv;
        end
      end
      psum[(OUT_ROWS-1-o)*PSUM_W +: PSUM_W] =
        PSUM_W'(saturate({{(32-SUM_W){acc[SUM_W-1]}}, acc}, PSUM_W, RELU));
    end
  end

endmodule

// File: rtl/conv_layer_stream.sv
// Streaming 3x3 conv layer: NUM_KERNEL filters over a 3-column sliding window,
// one-cycle output latency. Build with CONV_LAYER_STREAM_RELU_EN to clamp negatives to 0.
module conv_layer_stream
  import conv_pkg::*;
#(
  parameter int NUM_KERNEL = NUM_KERNEL_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WGT_W      = WGT_W_DEF,
  parameter int PSUM_W     = PSUM_W_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic                                   wgt_valid,
  output logic                                   wgt_ready,
  input  logic [3*WGT_W-1:0]                     wgt_data,
  output logic                                   wgt_loaded,
  input  logic                                   col_valid,
  output logic                                   col_ready,
  input  logic [ROWS*DATA_W-1:0]                 col_data,
  input  logic                                   col_last,
  output logic                                   psum_valid,
  input  logic                                   psum_ready,
  output logic [NUM_KERNEL*(ROWS-2)*PSUM_W-1:0]  psum_data,
  output logic                                   psum_last,
  output logic                                   frame_err
);

  localparam int OUT_ROWS = ROWS - 2;
  localparam int NB       = NUM_KERNEL * 3;
  localparam int BEAT_W   = beat_cnt_w(NUM_KERNEL);
  localparam int BEAT_DW  = 3 * WGT_W;
  localparam int KW       = 9 * WGT_W;
  localparam int COL_W    = ROWS * DATA_W;
  localparam int KOUT_W   = OUT_ROWS * PSUM_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

  state_e                          state_q, state_d;
  logic [BEAT_W-1:0]               beat_q, beat_d;
  logic [1:0]                      fill_q, fill_d;
  logic                            wgt_loaded_q, wgt_loaded_d;
  logic                            psum_valid_q, psum_valid_d;
  logic                            psum_last_q, psum_last_d;
  logic                            frame_err_q, frame_err_d;
  logic [NB*BEAT_DW-1:0]           bank_q, bank_d;
  logic [3*COL_W-1:0]              win_q, win_d, win_next;
  logic [NUM_KERNEL*KOUT_W-1:0]    psum_q, psum_d, kern_out;
  logic                            wgt_rdy, col_rdy, wgt_acc, col_acc;

  // Kernels see the window as it will be after the current column shifts in.
  assign win_next = {win_q[2*COL_W-1:0], col_data};

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_kern
    conv_kernel_col #(
      .ROWS   (ROWS),
      .DATA_W (DATA_W),
      .WGT_W  (WGT_W),
      .PSUM_W (PSUM_W)
    ) u_kern (
      .wgt  (bank_q[(NUM_KERNEL-1-k)*KW +: KW]),
      .win  (win_next),
      .psum (kern_out[(NUM_KERNEL-1-k)*KOUT_W +: KOUT_W])
    );
  end

  // A pending reload beat takes priority over a new frame's first column.
  always_comb begin
    wgt_rdy = en && ((state_q == ST_WLOAD) ||
                     (state_q == ST_FILL && fill_q == 2'd0 && !psum_valid_q));
    col_rdy = en && (state_q != ST_WLOAD) && (!psum_valid_q || psum_ready) &&
              !(wgt_rdy && wgt_valid);
    wgt_acc = wgt_valid && wgt_rdy;
    col_acc = col_valid && col_rdy;
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    fill_d       = fill_q;
    wgt_loaded_d = wgt_loaded_q;
    psum_valid_d = psum_valid_q;
    psum_last_d  = psum_last_q;
    frame_err_d  = 1'b0;
    bank_d       = bank_q;
    win_d        = win_q;
    psum_d       = psum_q;
    if (en) begin
      if (psum_valid_q && psum_ready) begin
        psum_valid_d = 1'b0;
        psum_last_d  = 1'b0;
      end
      case (state_q)
        ST_WLOAD: begin
          if (wgt_acc) begin
            bank_d[(NB-1-int'(beat_q))*BEAT_DW +: BEAT_DW] = wgt_data;
            if (beat_q == LAST_BEAT) begin
              beat_d       = '0;
              wgt_loaded_d = 1'b1;
              state_d      = ST_FILL;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        default: begin
          if (wgt_acc) begin
            bank_d[(NB-1)*BEAT_DW +: BEAT_DW] = wgt_data;
            beat_d       = BEAT_W'(1);
            wgt_loaded_d = 1'b0;
            state_d      = ST_WLOAD;
          end else if (col_acc) begin
            win_d = win_next;
            if (fill_q >= 2'd2) begin
              psum_valid_d = 1'b1;
              psum_d       = kern_out;
              psum_last_d  = col_last;
            end
            if (col_last) begin
              frame_err_d = (fill_q < 2'd2);
              fill_d      = 2'd0;
              state_d     = ST_FILL;
            end else if (fill_q >= 2'd2) begin
              fill_d  = 2'd3;
              state_d = ST_STREAM;
            end else begin
              fill_d = fill_q + 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WLOAD;
      beat_q       <= '0;
      fill_q       <= '0;
      wgt_loaded_q <= 1'b0;
      psum_valid_q <= 1'b0;
      psum_last_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      bank_q       <= '0;
      win_q        <= '0;
      psum_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      fill_q       <= fill_d;
      wgt_loaded_q <= wgt_loaded_d;
      psum_valid_q <= psum_valid_d;
      psum_last_q  <= psum_last_d;
      frame_err_q  <= frame_err_d;
      bank_q       <= bank_d;
      win_q        <= win_d;
      psum_q       <= psum_d;
    end
  end

  assign wgt_ready  = wgt_rdy;
  assign col_ready  = col_rdy;
  assign wgt_loaded = wgt_loaded_q;
  assign psum_valid = psum_valid_q;
  assign psum_last  = psum_last_q;
  assign psum_data  = psum_q;
  assign frame_err  = frame_err_q;

endmodule
